pm_fetch_pipe: RTL and testbench
================================

Name: pm_fetch_pipe

Overview:
Parametrised instruction-fetch unit for the microprocessor family that uses pipelined synchronous program ROM. It generates the program-memory address and ROM clock-enable, and tracks each in-flight fetch with an address/valid tag pipeline matched to a configurable ROM read latency. It delivers an aligned instruction, its PC and a valid flag to the decoder, and supports stall and jump-with-flush. It replaces the fixed one-stage fetch path and generalises address/data width and ROM latency.

Parameters:
ADDR_W, 8, program-counter and pm_address width
DATA_W, 8, instruction word width
ROM_LAT, 1, synchronous ROM read latency in cycles (legal 1..4)
RESET_VEC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
stall  in  1  decoder hold request; freezes fetch
jump_valid  in  1  load new PC this cycle
jump_addr  in  ADDR_W  jump target
pm_address_out  out  ADDR_W  ROM address (= pc, combinational from register)
pm_en  out  1  ROM clock-enable; ROM holds its pipeline when low
pm_data_in  in  DATA_W  ROM read data, valid ROM_LAT enabled cycles after address
pc  out  ADDR_W  current fetch PC
ir  out  DATA_W  registered instruction
ir_pc  out  ADDR_W  address ir was fetched from
ir_valid  out  1  ir holds a live instruction
flush_cnt  out  8  count of in-flight fetches discarded by jumps, saturating at 255

Behaviour:
- Reset (reset=0, async): pc=RESET_VEC; all tag valids=0; ir=0; ir_pc=0; ir_valid=0; flush_cnt=0. Outputs take these values immediately, not at the next edge. Release is sampled on the next rising clk.
- pm_address_out = pc. pm_en = ~stall | jump_valid.
- Tag pipeline: ROM_LAT stages of {addr, valid}. It advances only when pm_en=1. Stage 0 captures {pc, 1}; the last stage aligns with pm_data_in.
- PC update, priority high to low:
  - jump_valid: pc <= jump_addr; all tag valids <= 0; stage 0 still captures {pc, 0} so the current address is discarded; flush_cnt += number of valid tags plus 1, saturating.
  - stall: pc, tags and ir/ir_pc/ir_valid hold.
  - otherwise: pc <= pc + 1, modulo 2^ADDR_W (ADDR_W'1s wraps to 0).
- IR stage, when pm_en=1 and no jump: ir <= pm_data_in; ir_pc <= last tag addr; ir_valid <= last tag valid. On a jump, ir_valid <= 0 and ir holds its value.
- Latency: first ir_valid=1 occurs on the (ROM_LAT+1)th rising edge after reset release. After a jump, ir_valid stays 0 for ROM_LAT+1 cycles, then target instructions stream one per cycle.
- Stall with jump in the same cycle: the jump wins and pm_en=1.
- Back-to-back jumps: each jump flushes; only the last target streams.
- Jump to the current pc: still flushes; no special case.
- Reset mid-stream: everything is cleared asynchronously; no partial instruction survives.
- Widths: all pc arithmetic is ADDR_W bits; no carry out.

Decomposition:
- Shared package (mp_pkg) holds the pc_t/instr_t typedefs sized by ADDR_W/DATA_W, the RESET_VEC default and the ROM_LAT legal bounds.
- One sub-module, fetch_tag_pipe: a ROM_LAT-deep {addr, valid} shift register with enable and synchronous flush.
- PC logic, IR stage and flush counter live in the top module.

Test Plan:
- ROM_LAT=2, ROM model data = addr ^ 8'hA5; release reset -> ir_valid rises on the 3rd edge with ir=8'hA5, ir_pc=0, then ir=8'hA4, ir_pc=1, and so on every cycle.
- Assert stall for 4 cycles while ir_pc=5 -> pc, ir=8'hA0 and ir_pc=5 frozen, pm_en=0; after release the next ir_pc=6 with no gap or duplicate.
- jump_valid with jump_addr=8'h40 while pc=8'h10, two tags valid -> ir_valid=0 for 3 cycles, then ir_pc=8'h40, ir=8'hE5; flush_cnt=3.
- Jump and stall asserted together -> jump taken, pm_en=1, pc=target on the next edge.
- Run from pc=8'hFE -> ir_pc sequence FE, FF, 00, 01.
- Pull reset low asynchronously mid-cycle during streaming -> all outputs zero or RESET_VEC before the next clk edge; restart latency repeats ROM_LAT+1. Repeat with ROM_LAT=1 and ROM_LAT=4.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared types and constants for the pipelined-ROM instruction fetch path.
package mp_pkg;

    localparam int PM_ADDR_W    = 8;
    localparam int PM_DATA_W    = 8;
    localparam int PM_RESET_VEC = 0;

    // Supported synchronous ROM read latencies.
    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;

    typedef logic [PM_ADDR_W-1:0] pc_t;
    typedef logic [PM_DATA_W-1:0] instr_t;

endpackage

// File: rtl/fetch_tag_pipe.sv
// Address/valid tag shift register that tracks each fetch in flight through the ROM.
module fetch_tag_pipe #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              vld_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              vld_out,
    output logic [DEPTH-1:0]  vld_vec
);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0]             vld_q, vld_d;

    always_comb begin
        addr_d = addr_q;
        vld_d  = vld_q;
        if (en) begin
            addr_d[0] = addr_in;
            vld_d[0]  = vld_in;
            for (int i = 1; i < DEPTH; i++) begin
                addr_d[i] = addr_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
        // Addresses keep shifting on a flush so the ROM and tags stay aligned.
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign addr_out = addr_q[DEPTH-1];
    assign vld_out  = vld_q[DEPTH-1];
    assign vld_vec  = vld_q;

endmodule

// File: rtl/pm_fetch_pipe.sv
// Instruction fetch unit for a pipelined synchronous program ROM: PC, ROM enable,
// tag alignment, instruction register and jump-flush accounting.
module pm_fetch_pipe
    import mp_pkg::*;
#(
    parameter int                ADDR_W    = PM_ADDR_W,
    parameter int                DATA_W    = PM_DATA_W,
    parameter int                ROM_LAT   = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PM_RESET_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pm_address_out,
    output logic              pm_en,
    input  logic [DATA_W-1:0] pm_data_in,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic [7:0]        flush_cnt
);

    // Out-of-range latencies are clamped to the supported range.
    localparam int LAT = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                         (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {5'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [7:0]        flush_cnt_q, flush_cnt_d;

    logic [ADDR_W-1:0] tag_addr;
    logic              tag_vld;
    logic [LAT-1:0]    tag_vld_vec;
    logic [3:0]        n_discard;

    assign pm_en = ~stall | jump_valid;

    fetch_tag_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (LAT)
    ) u_tags (
        .clk      (clk),
        .rst_n    (reset),
        .en       (pm_en),
        .flush    (jump_valid),
        .addr_in  (pc_q),
        .vld_in   (~jump_valid),
        .addr_out (tag_addr),
        .vld_out  (tag_vld),
        .vld_vec  (tag_vld_vec)
    );

    // Every live tag plus the address being presented this cycle is discarded.
    always_comb begin
        n_discard = 4'd1;
        for (int i = 0; i < LAT; i++) begin
            n_discard = n_discard + 4'(tag_vld_vec[i]);
        end
    end

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        flush_cnt_d = flush_cnt_q;
        if (jump_valid) begin
            pc_d        = jump_addr;
            ir_valid_d  = 1'b0;
            flush_cnt_d = sat_add8(flush_cnt_q, n_discard);
        end else if (!stall) begin
            pc_d       = pc_q + ADDR_W'(1);
            ir_d       = pm_data_in;
            ir_pc_d    = tag_addr;
            ir_valid_d = tag_vld;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_VEC;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pm_address_out = pc_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign ir_pc          = ir_pc_q;
    assign ir_valid       = ir_valid_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pm_fetch_pipe.sv
// Directed bench: ROM_LAT=2 instance exercised fully, ROM_LAT=1 and 4 instances free-run for latency.
module tb_pm_fetch_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // ROM_LAT=2 instance
    logic       a_stall = 1'b0, a_jv = 1'b0;
    logic [7:0] a_ja = 8'h00;
    logic [7:0] a_addr, a_data, a_pc, a_ir, a_ir_pc, a_flush;
    logic       a_pm_en, a_irv;
    logic [7:0] rom_a [0:1];

    pm_fetch_pipe #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(2), .RESET_VEC(8'h00)) dut_a (
        .clk(clk), .reset(reset), .stall(a_stall), .jump_valid(a_jv), .jump_addr(a_ja),
        .pm_address_out(a_addr), .pm_en(a_pm_en), .pm_data_in(a_data), .pc(a_pc),
        .ir(a_ir), .ir_pc(a_ir_pc), .ir_valid(a_irv), .flush_cnt(a_flush));

    always_ff @(posedge clk) begin
        if (a_pm_en) begin
            rom_a[0] <= a_addr ^ 8'hA5;
            rom_a[1] <= rom_a[0];
        end
    end
    assign a_data = rom_a[1];

    // ROM_LAT=1 instance
    logic       b_stall = 1'b0, b_jv = 1'b0;
    logic [7:0] b_ja = 8'h00;
    logic [7:0] b_addr, b_data, b_pc, b_ir, b_ir_pc, b_flush;
    logic       b_pm_en, b_irv;
    logic [7:0] rom_b;

    pm_fetch_pipe #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(1), .RESET_VEC(8'h00)) dut_b (
        .clk(clk), .reset(reset), .stall(b_stall), .jump_valid(b_jv), .jump_addr(b_ja),
        .pm_address_out(b_addr), .pm_en(b_pm_en), .pm_data_in(b_data), .pc(b_pc),
        .ir(b_ir), .ir_pc(b_ir_pc), .ir_valid(b_irv), .flush_cnt(b_flush));

    always_ff @(posedge clk) begin
        if (b_pm_en) rom_b <= b_addr ^ 8'hA5;
    end
    assign b_data = rom_b;

    // ROM_LAT=4 instance
    logic       d_stall = 1'b0, d_jv = 1'b0;
    logic [7:0] d_ja = 8'h00;
    logic [7:0] d_addr, d_data, d_pc, d_ir, d_ir_pc, d_flush;
    logic       d_pm_en, d_irv;
    logic [7:0] rom_d [0:3];

    pm_fetch_pipe #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(4), .RESET_VEC(8'h00)) dut_d (
        .clk(clk), .reset(reset), .stall(d_stall), .jump_valid(d_jv), .jump_addr(d_ja),
        .pm_address_out(d_addr), .pm_en(d_pm_en), .pm_data_in(d_data), .pc(d_pc),
        .ir(d_ir), .ir_pc(d_ir_pc), .ir_valid(d_irv), .flush_cnt(d_flush));

    always_ff @(posedge clk) begin
        if (d_pm_en) begin
            rom_d[0] <= d_addr ^ 8'hA5;
            for (int i = 1; i < 4; i++) rom_d[i] <= rom_d[i-1];
        end
    end
    assign d_data = rom_d[3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int         first_a, first_b, first_d;
    logic [7:0] fir_a, fir_b, fir_d;

    initial begin
        // asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1;
        chk("rst_pc", a_pc, 8'h00);
        chk("rst_ir", a_ir, 8'h00);
        chk("rst_ir_pc", a_ir_pc, 8'h00);
        chk("rst_ir_valid", 8'(a_irv), 8'h00);
        chk("rst_flush", a_flush, 8'h00);
        chk("rst_pm_en", 8'(a_pm_en), 8'h01);
        #10 reset = 1'b1;

        tick(); // e1
        chk("e1_pc", a_pc, 8'h01);
        chk("e1_addr", a_addr, 8'h01);
        chk("e1_irv", 8'(a_irv), 8'h00);
        chk("e1_b_irv", 8'(b_irv), 8'h00);
        tick(); // e2
        chk("e2_irv", 8'(a_irv), 8'h00);
        chk("e2_b_irv", 8'(b_irv), 8'h01);
        chk("e2_b_ir", b_ir, 8'hA5);
        chk("e2_b_ir_pc", b_ir_pc, 8'h00);
        tick(); // e3
        chk("e3_irv", 8'(a_irv), 8'h01);
        chk("e3_ir", a_ir, 8'hA5);
        chk("e3_ir_pc", a_ir_pc, 8'h00);
        tick(); // e4
        chk("e4_ir", a_ir, 8'hA4);
        chk("e4_ir_pc", a_ir_pc, 8'h01);
        chk("e4_d_irv", 8'(d_irv), 8'h00);
        tick(); // e5
        chk("e5_d_irv", 8'(d_irv), 8'h01);
        chk("e5_d_ir", d_ir, 8'hA5);
        chk("e5_d_ir_pc", d_ir_pc, 8'h00);
        chk("e5_ir_pc", a_ir_pc, 8'h02);
        tick(3); // e8
        chk("e8_ir_pc", a_ir_pc, 8'h05);
        chk("e8_ir", a_ir, 8'hA0);
        chk("e8_pc", a_pc, 8'h08);

        // stall for four cycles
        a_stall = 1'b1;
        #1;
        chk("stall_pm_en", 8'(a_pm_en), 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_pc", a_pc, 8'h08);
            chk("stall_ir", a_ir, 8'hA0);
            chk("stall_ir_pc", a_ir_pc, 8'h05);
            chk("stall_irv", 8'(a_irv), 8'h01);
        end
        a_stall = 1'b0;
        tick();
        chk("unstall_ir_pc", a_ir_pc, 8'h06);
        chk("unstall_ir", a_ir, 8'hA3);
        chk("unstall_pc", a_pc, 8'h09);
        tick(7);
        chk("pre_jump_pc", a_pc, 8'h10);
        chk("pre_jump_ir_pc", a_ir_pc, 8'h0D);

        // jump with two live tags
        a_jv = 1'b1; a_ja = 8'h40;
        tick();
        chk("jmp_pc", a_pc, 8'h40);
        chk("jmp_flush", a_flush, 8'h03);
        chk("jmp_irv0", 8'(a_irv), 8'h00);
        a_jv = 1'b0;
        tick();
        chk("jmp_irv1", 8'(a_irv), 8'h00);
        tick();
        chk("jmp_irv2", 8'(a_irv), 8'h00);
        tick();
        chk("jmp_irv3", 8'(a_irv), 8'h01);
        chk("jmp_ir_pc", a_ir_pc, 8'h40);
        chk("jmp_ir", a_ir, 8'hE5);

        // jump and stall together
        a_stall = 1'b1; a_jv = 1'b1; a_ja = 8'h80;
        #1;
        chk("js_pm_en", 8'(a_pm_en), 8'h01);
        tick();
        chk("js_pc", a_pc, 8'h80);
        chk("js_flush", a_flush, 8'h06);
        a_stall = 1'b0;

        // back-to-back jumps
        a_ja = 8'h20;
        tick();
        chk("bb1_pc", a_pc, 8'h20);
        chk("bb1_flush", a_flush, 8'h07);
        a_ja = 8'h30;
        tick();
        chk("bb2_pc", a_pc, 8'h30);
        chk("bb2_flush", a_flush, 8'h08);
        a_jv = 1'b0;
        tick();
        chk("bb_irv1", 8'(a_irv), 8'h00);
        tick();
        chk("bb_irv2", 8'(a_irv), 8'h00);
        tick();
        chk("bb_irv3", 8'(a_irv), 8'h01);
        chk("bb_ir_pc", a_ir_pc, 8'h30);
        chk("bb_ir", a_ir, 8'h95);

        // jump to the current pc
        chk("self_pc_before", a_pc, 8'h33);
        a_jv = 1'b1; a_ja = 8'h33;
        tick();
        chk("self_pc", a_pc, 8'h33);
        chk("self_flush", a_flush, 8'h0B);
        chk("self_irv", 8'(a_irv), 8'h00);
        a_jv = 1'b0;
        tick(3);
        chk("self_ir_pc", a_ir_pc, 8'h33);
        chk("self_ir", a_ir, 8'h96);

        // pc wrap-around
        a_jv = 1'b1; a_ja = 8'hFE;
        tick();
        chk("wrap_pc", a_pc, 8'hFE);
        chk("wrap_flush", a_flush, 8'h0E);
        a_jv = 1'b0;
        tick(2);
        chk("wrap_pc0", a_pc, 8'h00);
        tick();
        chk("wrap_ir_pc_fe", a_ir_pc, 8'hFE);
        chk("wrap_ir_fe", a_ir, 8'h5B);
        tick();
        chk("wrap_ir_pc_ff", a_ir_pc, 8'hFF);
        chk("wrap_ir_ff", a_ir, 8'h5A);
        tick();
        chk("wrap_ir_pc_00", a_ir_pc, 8'h00);
        chk("wrap_ir_00", a_ir, 8'hA5);
        tick();
        chk("wrap_ir_pc_01", a_ir_pc, 8'h01);
        chk("wrap_ir_01", a_ir, 8'hA4);

        // flush counter saturation
        a_jv = 1'b1; a_ja = 8'h00;
        tick();
        chk("sat_first", a_flush, 8'h11);
        tick(249);
        chk("sat_255", a_flush, 8'hFF);
        tick();
        chk("sat_hold", a_flush, 8'hFF);
        a_jv = 1'b0;

        // asynchronous reset while streaming
        tick(6);
        chk("pre_rst_irv", 8'(a_irv), 8'h01);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_pc", a_pc, 8'h00);
        chk("mid_rst_ir", a_ir, 8'h00);
        chk("mid_rst_ir_pc", a_ir_pc, 8'h00);
        chk("mid_rst_irv", 8'(a_irv), 8'h00);
        chk("mid_rst_flush", a_flush, 8'h00);
        chk("mid_rst_b_irv", 8'(b_irv), 8'h00);
        chk("mid_rst_d_irv", 8'(d_irv), 8'h00);
        chk("mid_rst_d_pc", d_pc, 8'h00);
        #2 reset = 1'b1;

        first_a = 0; first_b = 0; first_d = 0;
        fir_a = 8'h00; fir_b = 8'h00; fir_d = 8'h00;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (first_a == 0 && a_irv) begin first_a = n; fir_a = a_ir; end
            if (first_b == 0 && b_irv) begin first_b = n; fir_b = b_ir; end
            if (first_d == 0 && d_irv) begin first_d = n; fir_d = d_ir; end
        end
        chk("restart_lat2", 8'(first_a), 8'd3);
        chk("restart_lat1", 8'(first_b), 8'd2);
        chk("restart_lat4", 8'(first_d), 8'd5);
        chk("restart_ir2", fir_a, 8'hA5);
        chk("restart_ir1", fir_b, 8'hA5);
        chk("restart_ir4", fir_d, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
